// File: rtl/hyper_pipe_sink.sv
// hyper_pipe_sink
// ---------------
// Receive-side endpoint for a valid/data stream that travels over
// hyper-pipelined links. The forward link (in_valid/in_data) arrives through
// NUM_PIPES register stages and the throttle (up_ready) goes back through
// another NUM_PIPES stages. The round trip is therefore 2*NUM_PIPES cycles.
// The circular buffer keeps SKID entries of headroom so that every flit still
// in flight when the throttle drops can be absorbed.
//
// Handshake: the downstream side uses strict valid/ready. A flit transfers on
// a rising clk edge where out_valid && out_ready. out_valid does not depend on
// out_ready. Once out_valid is raised, out_data stays stable until the
// transfer. The upstream side has no ready. A flit is offered on every cycle
// in_valid is high, whether or not up_ready is set.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   forward-link flit valid (already delayed by NUM_PIPES)
//   in_data    forward-link flit payload, WIDTH bits
//   up_ready   registered credit flag to the upstream sender
//   out_valid  downstream flit valid
//   out_data   downstream flit payload, show-ahead from the buffer head
//   out_ready  downstream accept
//   occupancy  current entry count, $clog2(DEPTH)+1 bits
//   overflow   sticky flag, set when a flit was dropped for lack of space
module hyper_pipe_sink #(
  parameter int WIDTH     = 512,
  parameter int NUM_PIPES = 4,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     up_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
);

  localparam int SKID = 2 * NUM_PIPES + 2;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] CREDIT_THR = CW'(DEPTH - SKID);

  // The pointers wrap for free only when DEPTH is a power of two. The SKID
  // headroom must also leave at least one usable entry below the threshold.
  generate
    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2 * NUM_PIPES + 3)) begin : g_bad_depth
      $error("hyper_pipe_sink: DEPTH must be a power of two and >= 2*NUM_PIPES+3");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             pop;
  logic             push_ok;
  logic             drop;

  always_comb begin
    pop        = 1'b0;
    push_ok    = 1'b0;
    drop       = 1'b0;
    count_next = count;

    pop = out_valid && out_ready;
    // At full, a push is still accepted when a pop frees the head slot on
    // the same edge. That write lands at wr_ptr == rd_ptr. The head is read
    // combinationally before the edge, so nothing is lost.
    push_ok    = in_valid && ((count < FULL_CNT) || pop);
    drop       = in_valid && !push_ok;
    count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign occupancy = count;

  // Buffer RAM carries no reset. Contents are only observed behind count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      up_ready <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      // The credit flag is the only throttle. It looks at the post-edge count
      // so that the SKID headroom covers the whole return-trip latency.
      up_ready <= (count_next <= CREDIT_THR);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hyper_pipe_sink.sv
module tb_hyper_pipe_sink;

  localparam int W     = 32;
  localparam int NP    = 4;
  localparam int DEPTH = 16;
  localparam int THR   = 6;
  localparam int CW    = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          up_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] occupancy;
  logic          overflow;

  hyper_pipe_sink #(.WIDTH(W), .NUM_PIPES(NP), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .up_ready  (up_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  // ---------------- hyper-pipe links around the DUT ----------------
  logic          use_pipe;
  logic          drv_valid;
  logic [W-1:0]  drv_data;
  logic          src_valid;
  logic [W-1:0]  src_data;
  logic [NP-1:0] fwd_v;
  logic [W-1:0]  fwd_d [NP];
  logic [NP-1:0] ret_r;
  logic          up_seen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_v <= '0;
      ret_r <= '0;
      for (int i = 0; i < NP; i++) fwd_d[i] <= '0;
    end else begin
      fwd_v    <= {fwd_v[NP-2:0], src_valid};
      fwd_d[0] <= src_data;
      for (int i = 1; i < NP; i++) fwd_d[i] <= fwd_d[i-1];
      ret_r    <= {ret_r[NP-2:0], up_ready};
    end
  end

  assign up_seen  = ret_r[NP-1];
  assign in_valid = use_pipe ? fwd_v[NP-1] : drv_valid;
  assign in_data  = use_pipe ? fwd_d[NP-1] : drv_data;

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  int  m_occ;
  bit  m_ovf;
  bit  m_up;
  int  peak;
  int  n_vec;
  int  n_err;
  int  seq;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the inputs now applied, compare popped data before
  // the edge, then compare the registered state just after the edge.
  task automatic tick();
    bit p;
    bit q;
    logic [W-1:0] e;
    #2;
    p = (m_occ != 0) && out_ready;
    q = in_valid && ((m_occ < DEPTH) || p);
    if (in_valid && !q) m_ovf = 1'b1;
    if (p) begin
      e = exp_q.pop_front();
      check("out_data", out_data, e);
    end
    if (q) exp_q.push_back(in_data);
    m_occ = m_occ + int'(q) - int'(p);
    m_up  = (m_occ <= THR);
    @(posedge clk);
    #1;
    check("occupancy", W'(occupancy), W'(m_occ));
    check("out_valid", W'(out_valid), W'(m_occ != 0));
    check("up_ready",  W'(up_ready),  W'(m_up));
    check("overflow",  W'(overflow),  W'(m_ovf));
    if (int'(occupancy) > peak) peak = int'(occupancy);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec = 0; n_err = 0; m_occ = 0; m_ovf = 0; m_up = 0; peak = 0; seq = 0;
    use_pipe = 1'b0; drv_valid = 1'b0; drv_data = '0;
    src_valid = 1'b0; src_data = '0; out_ready = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_occupancy", W'(occupancy), 0);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_up_ready",  W'(up_ready),  0);
    check("rst_overflow",  W'(overflow),  0);
    rst_n = 1'b1;
    tick();
    check("first_edge_up_ready", W'(up_ready), 1);
    repeat (4) tick();

    // Single flit
    out_ready = 1'b1;
    drv_valid = 1'b1; drv_data = 'hA5;
    tick();
    drv_valid = 1'b0;
    check("single_valid", W'(out_valid), 1);
    check("single_data",  out_data, 'hA5);
    tick();
    check("single_drained", W'(occupancy), 0);

    // Stall with a compliant sender through the real links
    use_pipe = 1'b1; out_ready = 1'b0; seq = 0; peak = 0;
    repeat (30) begin
      src_valid = up_seen;
      src_data  = W'(seq);
      tick();
      if (src_valid) seq++;
    end
    src_valid = 1'b0;
    check("stall_peak_le_depth", W'(peak <= DEPTH), 1);
    check("stall_no_overflow",   W'(overflow), 0);
    check("stall_throttled",     W'(up_ready), 0);
    out_ready = 1'b1;
    repeat (40) tick();
    check("stall_drained", W'(exp_q.size()), 0);
    check("stall_up_ready_back", W'(up_ready), 1);

    // Full with simultaneous push and pop across the pointer wrap
    use_pipe = 1'b0; out_ready = 1'b0; drv_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drv_data = W'(100 + i);
      tick();
    end
    check("full_count", W'(occupancy), 16);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drv_data = W'(200 + i);
      tick();
      check("full_hold", W'(occupancy), 16);
    end
    check("full_no_drop", W'(overflow), 0);
    drv_valid = 1'b0;
    repeat (20) tick();
    check("full_drained", W'(exp_q.size()), 0);

    // Forced overflow by a non-compliant sender
    out_ready = 1'b0; drv_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drv_data = W'(300 + i);
      tick();
    end
    drv_valid = 1'b0;
    check("ovf_set",   W'(overflow),  1);
    check("ovf_count", W'(occupancy), 16);
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (20) tick();
    check("ovf_sticky",  W'(overflow), 1);
    check("ovf_drained", W'(exp_q.size()), 0);

    // Async reset mid-stream at occupancy 9
    out_ready = 1'b0; drv_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drv_data = W'(400 + i);
      tick();
    end
    drv_valid = 1'b0;
    check("pre_reset_count", W'(occupancy), 9);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_occupancy", W'(occupancy), 0);
    check("async_out_valid", W'(out_valid), 0);
    check("async_up_ready",  W'(up_ready),  0);
    check("async_overflow",  W'(overflow),  0);
    m_occ = 0; m_ovf = 1'b0; m_up = 1'b0; exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    repeat (3) tick();

    // Resume streaming through the links with random downstream stalls
    use_pipe = 1'b1; seq = 1000;
    repeat (40) begin
      src_valid = up_seen;
      src_data  = W'(seq);
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (src_valid) seq++;
    end
    src_valid = 1'b0; out_ready = 1'b1;
    repeat (40) tick();
    check("resume_drained", W'(exp_q.size()), 0);
    check("resume_no_overflow", W'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
